// File: rtl/spi_mem_bridge_if.sv
// Memory/register bus between spi_mem_bridge (master) and the video core (slave).
`timescale 1ns / 1ps

interface spi_mem_bridge_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned CTRL_W = 7
) ();
  logic [CTRL_W-1:0] ctrl;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        wdata;
  logic              wr_en;
  logic              rd_en;
  logic [7:0]        rdata;

  modport master (output ctrl, addr, wdata, wr_en, rd_en, input rdata);
  modport slave  (input ctrl, addr, wdata, wr_en, rd_en, output rdata);
endinterface

// File: rtl/spi_mem_bridge.sv
// Oversampled SPI slave (mode 0) driving a single-clock memory/register bus.
// Read-back is built only when SPI_MEM_BRIDGE_READ_EN is defined.
`timescale 1ns / 1ps

module spi_mem_bridge #(
  parameter int unsigned ADDR_W      = 15,
  parameter int unsigned CTRL_W      = 7,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  ID_BYTE     = 8'hA0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck,
  input  logic              mosi,
  input  logic              ssel,
  output logic              miso,
  output logic              busy,
  spi_mem_bridge_if.master  bus
);

  localparam int unsigned ADDR_BYTES = (ADDR_W + 7) / 8;
  localparam int unsigned ASH_W      = ADDR_BYTES * 8;
  localparam logic [7:0]  LAST_ADDR  = 8'(ADDR_BYTES - 1);

  typedef enum logic [1:0] {StIdle, StCmd, StAddr, StData} state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q, mosi_sync_q, ssel_sync_q;
  logic                   sck_prev_q, ssel_prev_q;
  logic                   sck_s, mosi_s, ssel_s;
  logic                   sck_rise, sck_fall, ssel_fall;

  // ssel history resets low so a select already asserted at reset is ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      ssel_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      ssel_prev_q <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      ssel_sync_q <= {ssel_sync_q[SYNC_STAGES-2:0], ssel};
      sck_prev_q  <= sck_s;
      ssel_prev_q <= ssel_s;
    end
  end

  assign sck_s     = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign ssel_s    = ssel_sync_q[SYNC_STAGES-1];
  assign sck_rise  = sck_s & ~sck_prev_q;
  assign sck_fall  = ~sck_s & sck_prev_q;
  assign ssel_fall = ssel_prev_q & ~ssel_s;

  state_e            state_q;
  logic [2:0]        bit_cnt_q;
  logic [7:0]        rx_q, tx_q;
  logic [7:0]        addr_cnt_q;
  logic [ASH_W-1:0]  addr_sh_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [7:0]        wdata_q;
  logic              wr_en_q, rd_mode_q, miso_q;
  logic [7:0]        rx_next;
  logic [ASH_W-1:0]  addr_asm;

  assign rx_next  = {rx_q[6:0], mosi_s};
  assign addr_asm = ASH_W'({addr_sh_q, rx_next});

`ifdef SPI_MEM_BRIDGE_READ_EN
  logic rd_en_q, rd_pend_q;
`else
  logic rdata_unused;
  assign rdata_unused = ^bus.rdata;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bit_cnt_q  <= 3'd0;
      rx_q       <= 8'h00;
      tx_q       <= ID_BYTE;
      addr_cnt_q <= 8'h00;
      addr_sh_q  <= '0;
      addr_q     <= '0;
      ctrl_q     <= '0;
      wdata_q    <= 8'h00;
      wr_en_q    <= 1'b0;
      rd_mode_q  <= 1'b0;
      miso_q     <= 1'b0;
`ifdef SPI_MEM_BRIDGE_READ_EN
      rd_en_q    <= 1'b0;
      rd_pend_q  <= 1'b0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      miso_q  <= (state_q == StIdle) ? 1'b0 : tx_q[7];
`ifdef SPI_MEM_BRIDGE_READ_EN
      rd_en_q   <= 1'b0;
      rd_pend_q <= rd_en_q;
`endif
      if (wr_en_q) addr_q <= addr_q + ADDR_W'(1);
      // The trailing fall after bit 8 must not shift: the next byte's MSB is already loaded
      if (sck_fall && state_q != StIdle && bit_cnt_q != 3'd0) tx_q <= {tx_q[6:0], 1'b0};

      case (state_q)
        StIdle: begin
          if (ssel_fall) begin
            state_q   <= StCmd;
            bit_cnt_q <= 3'd0;
            tx_q      <= ID_BYTE;
          end
        end
        default: begin
          if (ssel_s) begin
            state_q <= StIdle;
          end else if (sck_rise) begin
            rx_q      <= rx_next;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              tx_q <= ID_BYTE;
              case (state_q)
                StCmd: begin
                  ctrl_q     <= rx_next[CTRL_W-1:0];
                  rd_mode_q  <= rx_next[7];
                  addr_cnt_q <= 8'h00;
                  addr_sh_q  <= '0;
                  state_q    <= StAddr;
                end
                StAddr: begin
                  addr_sh_q <= addr_asm;
                  if (addr_cnt_q == LAST_ADDR) begin
                    addr_q  <= ADDR_W'(addr_asm);
                    state_q <= StData;
`ifdef SPI_MEM_BRIDGE_READ_EN
                    if (rd_mode_q) rd_en_q <= 1'b1;
`endif
                  end else begin
                    addr_cnt_q <= addr_cnt_q + 8'd1;
                  end
                end
                default: begin
                  if (!rd_mode_q) begin
                    wdata_q <= rx_next;
                    wr_en_q <= 1'b1;
                  end
`ifdef SPI_MEM_BRIDGE_READ_EN
                  else begin
                    rd_en_q <= 1'b1;
                  end
`endif
                end
              endcase
            end
          end
        end
      endcase

`ifdef SPI_MEM_BRIDGE_READ_EN
      // rdata is valid the cycle after rd_en; load it and step to the prefetch address
      if (rd_pend_q) begin
        tx_q   <= bus.rdata;
        addr_q <= addr_q + ADDR_W'(1);
      end
`endif
    end
  end

  assign miso      = miso_q;
  assign busy      = (state_q != StIdle);
  assign bus.ctrl  = ctrl_q;
  assign bus.addr  = addr_q;
  assign bus.wdata = wdata_q;
  assign bus.wr_en = wr_en_q;
`ifdef SPI_MEM_BRIDGE_READ_EN
  assign bus.rd_en = rd_en_q;
`else
  assign bus.rd_en = 1'b0;
`endif

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Directed bench for spi_mem_bridge: write burst, wrap, abort, read-back, reset mid-frame.
`timescale 1ns / 1ps

module tb_spi_mem_bridge;

  localparam int unsigned ADDR_W      = 15;
  localparam int unsigned CTRL_W      = 7;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int          HALF        = 100;

  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sck = 1'b0;
  logic mosi = 1'b0;
  logic ssel = 1'b1;
  logic miso, busy;

  int n_checks = 0;
  int n_errors = 0;
  int both_cnt = 0;

  logic [ADDR_W+7:0] wr_log[$];
  logic [ADDR_W-1:0] rd_log[$];

  spi_mem_bridge_if #(.ADDR_W(ADDR_W), .CTRL_W(CTRL_W)) bus ();

  spi_mem_bridge #(
    .ADDR_W      (ADDR_W),
    .CTRL_W      (CTRL_W),
    .SYNC_STAGES (SYNC_STAGES),
    .ID_BYTE     (8'hA0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sck   (sck),
    .mosi  (mosi),
    .ssel  (ssel),
    .miso  (miso),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory model: rdata = addr[7:0], valid one clk after rd_en
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.rdata <= 8'h00;
    else if (bus.rd_en) bus.rdata <= bus.addr[7:0];
  end

  always @(negedge clk) begin
    if (bus.wr_en) wr_log.push_back({bus.addr, bus.wdata});
    if (bus.rd_en) rd_log.push_back(bus.addr);
    if (bus.wr_en && bus.rd_en) both_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wr_at(input int i);
    if (wr_log.size() > i) return 32'(wr_log[i]);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] rd_at(input int i);
    if (rd_log.size() > i) return 32'(rd_log[i]);
    return 32'hFFFF_FFFF;
  endfunction

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi = tx[7-i];
      #(HALF);
      rx[7-i] = miso;
      sck = 1'b1;
      #(HALF);
      sck = 1'b0;
    end
  endtask

  task automatic spi_xfer(input byte_q_t txq, output byte_q_t rxq);
    logic [7:0] b;
    rxq.delete();
    foreach (txq[i]) begin
      spi_bits(txq[i], 8, b);
      rxq.push_back(b);
    end
  endtask

  task automatic frame_open();
    ssel = 1'b0;
    #(2 * HALF);
  endtask

  task automatic frame_close();
    #(HALF);
    ssel = 1'b1;
    #(4 * HALF);
  endtask

  task automatic clear_logs();
    wr_log.delete();
    rd_log.delete();
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_miso"},  32'(miso),      32'h0);
    check_eq({pfx, "_busy"},  32'(busy),      32'h0);
    check_eq({pfx, "_ctrl"},  32'(bus.ctrl),  32'h0);
    check_eq({pfx, "_addr"},  32'(bus.addr),  32'h0);
    check_eq({pfx, "_wdata"}, 32'(bus.wdata), 32'h0);
    check_eq({pfx, "_wr_en"}, 32'(bus.wr_en), 32'h0);
    check_eq({pfx, "_rd_en"}, 32'(bus.rd_en), 32'h0);
  endtask

  initial begin
    byte_q_t    txq, rxq;
    logic [7:0] b;
    int         n;

    // Reset values
    #20;
    check_reset_outputs("rst");
    #20;
    rst_n = 1'b1;
    #(2 * HALF);

    // Write burst
    clear_logs();
    frame_open();
    txq = '{8'h05, 8'h12, 8'h34, 8'hAA, 8'hBB};
    spi_xfer(txq, rxq);
    check_eq("wb_busy_open", 32'(busy), 32'h1);
    check_eq("wb_ctrl", 32'(bus.ctrl), 32'h5);
    check_eq("wb_count", 32'(wr_log.size()), 32'd2);
    check_eq("wb_wr0", wr_at(0), {9'h0, 15'h1234, 8'hAA});
    check_eq("wb_wr1", wr_at(1), {9'h0, 15'h1235, 8'hBB});
    check_eq("wb_addr_after", 32'(bus.addr), 32'h1236);
    foreach (rxq[i]) check_eq($sformatf("wb_miso%0d", i), 32'(rxq[i]), 32'hA0);
    #(HALF);
    @(negedge clk);
    ssel = 1'b1;
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("wb_busy_drop_in_time", 32'(n <= SYNC_STAGES + 2), 32'h1);
    #(4 * HALF);

    // Address wrap
    clear_logs();
    frame_open();
    txq = '{8'h00, 8'h7F, 8'hFF, 8'h11, 8'h22};
    spi_xfer(txq, rxq);
    frame_close();
    check_eq("wrap_count", 32'(wr_log.size()), 32'd2);
    check_eq("wrap_wr0", wr_at(0), {9'h0, 15'h7FFF, 8'h11});
    check_eq("wrap_wr1", wr_at(1), {9'h0, 15'h0000, 8'h22});
    check_eq("wrap_ctrl", 32'(bus.ctrl), 32'h0);

    // Abort mid data byte
    clear_logs();
    frame_open();
    txq = '{8'h01, 8'h00, 8'h50};
    spi_xfer(txq, rxq);
    spi_bits(8'hCC, 4, b);
    frame_close();
    check_eq("abort_no_wr", 32'(wr_log.size()), 32'd0);
    check_eq("abort_ctrl", 32'(bus.ctrl), 32'h1);
    check_eq("abort_addr", 32'(bus.addr), 32'h0050);
    check_eq("abort_idle", 32'(busy), 32'h0);
    frame_open();
    txq = '{8'h01, 8'h00, 8'h00, 8'h33};
    spi_xfer(txq, rxq);
    frame_close();
    check_eq("after_abort_count", 32'(wr_log.size()), 32'd1);
    check_eq("after_abort_wr0", wr_at(0), {9'h0, 15'h0000, 8'h33});

    // Read frame
    clear_logs();
    frame_open();
    txq = '{8'h83, 8'h00, 8'h10, 8'h00, 8'h00};
    spi_xfer(txq, rxq);
    frame_close();
    check_eq("rd_ctrl", 32'(bus.ctrl), 32'h3);
    check_eq("rd_no_wr", 32'(wr_log.size()), 32'd0);
    check_eq("rd_no_overlap", 32'(both_cnt), 32'd0);
    check_eq("rd_miso0", 32'(rxq[0]), 32'hA0);
    check_eq("rd_miso1", 32'(rxq[1]), 32'hA0);
    check_eq("rd_miso2", 32'(rxq[2]), 32'hA0);
`ifdef SPI_MEM_BRIDGE_READ_EN
    check_eq("rd_miso3", 32'(rxq[3]), 32'h10);
    check_eq("rd_miso4", 32'(rxq[4]), 32'h11);
    check_eq("rd_count", 32'(rd_log.size()), 32'd3);
    check_eq("rd_addr0", rd_at(0), 32'h0010);
    check_eq("rd_addr1", rd_at(1), 32'h0011);
    check_eq("rd_addr2", rd_at(2), 32'h0012);
    check_eq("rd_addr_after", 32'(bus.addr), 32'h0013);
`else
    check_eq("rd_miso3", 32'(rxq[3]), 32'hA0);
    check_eq("rd_miso4", 32'(rxq[4]), 32'hA0);
    check_eq("rd_count", 32'(rd_log.size()), 32'd0);
    check_eq("rd_addr_after", 32'(bus.addr), 32'h0010);
`endif

    // Reset in the middle of an address byte, ssel held low
    clear_logs();
    frame_open();
    spi_bits(8'h05, 8, b);
    spi_bits(8'h12, 4, b);
    rst_n = 1'b0;
    #10;
    check_reset_outputs("midrst");
    #20;
    rst_n = 1'b1;
    spi_bits(8'h12, 4, b);
    txq = '{8'h00, 8'h77, 8'h01};
    spi_xfer(txq, rxq);
    check_eq("midrst_no_wr", 32'(wr_log.size()), 32'd0);
    check_eq("midrst_idle", 32'(busy), 32'h0);
    check_eq("midrst_ctrl", 32'(bus.ctrl), 32'h0);
    frame_close();
    frame_open();
    txq = '{8'h02, 8'h00, 8'h05, 8'h44};
    spi_xfer(txq, rxq);
    frame_close();
    check_eq("rearm_count", 32'(wr_log.size()), 32'd1);
    check_eq("rearm_wr0", wr_at(0), {9'h0, 15'h0005, 8'h44});
    check_eq("rearm_ctrl", 32'(bus.ctrl), 32'h2);
    check_eq("final_no_overlap", 32'(both_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_mem_bridge.md
# spi_mem_bridge

Single-clock SPI slave that turns the host's byte stream into a parametrised memory/register bus for the video core. It is the successor to the SCK-clocked SPI receiver and command decoder. SCK, MOSI and SSEL are oversampled in the pixel-clock domain, so the display RAM becomes an ordinary single-clock write port. It adds read-back, configurable address width, a configurable control field, abort-safe framing and address wrap.

## Interface

Parameters:
- ADDR_W, 15, memory address width in bits; address bytes per frame ADDR_BYTES = (ADDR_W+7)/8.
- CTRL_W, 7, width of the control field carried in the command byte (1..7).
- SYNC_STAGES, 2, synchroniser depth for sck/mosi/ssel (≥2).
- ID_BYTE, 8'hA0, byte returned on miso when no read data is being shifted.

Ports:
- clk  in  1  system/pixel clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sck  in  1  SPI clock, mode 0, asynchronous to clk.
- mosi  in  1  SPI data in, MSB first.
- ssel  in  1  SPI select, active low.
- miso  out  1  SPI data out, MSB first.
- ctrl  out  CTRL_W  control field from the last completed command byte.
- addr  out  ADDR_W  bus address.
- wdata  out  8  write data.
- wr_en  out  1  one-cycle write strobe.
- rd_en  out  1  one-cycle read strobe.
- rdata  in  8  read data, valid exactly 1 clk after rd_en.
- busy  out  1  high while a frame is open (state ≠ IDLE).

## Operation

- The frame is: command byte, then ADDR_BYTES address bytes (big-endian; unused MSBs of the first byte are ignored), then any number of data bytes.
  - Command byte bit 7 selects the mode: 0 = write, 1 = read.
  - Command bits [CTRL_W-1:0] are latched into ctrl when the command byte completes.
- FSM states:
  - IDLE → CMD on a synchronised ssel falling edge.
  - CMD → ADDR after 8 bits.
  - ADDR → DATA after ADDR_BYTES bytes.
  - DATA stays in DATA.
  - Any state → IDLE on synchronised ssel high.
- The bit counter resets to 0 on entering CMD and on every byte boundary.
- Write mode: each completed data byte drives wdata and pulses wr_en for one cycle at the current addr. addr increments the cycle after wr_en.
- Read mode:
  - When the last address byte completes, rd_en pulses at addr.
  - rdata is captured into the tx shift register on the following cycle, and addr then increments.
  - Each completed data byte triggers the next rd_en/capture, so the following byte is prefetched.
- miso:
  - The tx shift register shifts on the synchronised sck falling edge, and miso = tx[7].
  - It holds ID_BYTE during CMD and ADDR, and in write-mode DATA.
- addr wraps modulo 2^ADDR_W; 2^ADDR_W−1 is followed by 0.
- ssel deasserted mid-byte: the partial byte is discarded, no strobe is issued, and ctrl/addr keep their last values.
- After reset the FSM sits in IDLE. If ssel is already low, nothing is accepted until ssel goes high and then low again.

## Timing

- Reset values: miso 0, ctrl 0, addr 0, wdata 0, wr_en 0, rd_en 0, busy 0, FSM IDLE, tx = ID_BYTE.
- An sck edge is detected SYNC_STAGES+1 clk cycles after the pin transition. mosi is sampled from the same synchroniser stage as the edge.
- Required ratio: f_sck ≤ f_clk/8.
- wr_en asserts 1 clk after detection of the 8th rising edge of a data byte.
- rd_en asserts 1 clk after detection of the last address or data byte's 8th rising edge. The tx load occurs 1 clk later, before the next sck falling-edge detection.
- ctrl updates on the same cycle a write strobe would occur for the command byte.
- wr_en and rd_en are never high together. At most one strobe occurs per byte.

## Configuration

- SPI_MEM_BRIDGE_READ_EN defined: read mode, rd_en and rdata capture are built as described.
- Not defined:
  - rd_en is tied 0 and rdata is ignored.
  - A command with bit 7 set still updates ctrl and addr, but its data bytes produce no strobes.
  - miso returns ID_BYTE for the whole frame.

## Test plan

- Write burst: ADDR_W=15; frame 0x05, 0x12, 0x34, 0xAA, 0xBB → ctrl=5; wr_en with addr 0x1234/wdata 0xAA, then 0x1235/0xBB; busy drops ≤ SYNC_STAGES+2 clk after ssel high.
- Wrap: frame 0x00, 0x7F, 0xFF, 0x11, 0x22 → writes at 0x7FFF then 0x0000.
- Abort: ssel high after 4 bits of the first data byte → no wr_en; the next frame 0x01, 0x00, 0x00, 0x33 writes 0x33 at 0x0000.
- Read (READ_EN): model rdata = addr[7:0]; frame 0x83, 0x00, 0x10, then 2 dummy bytes → miso returns 0xA0 ×3, then 0x10, 0x11; rd_en pulses at 0x0010, 0x0011, 0x0012; no wr_en.
- Read, READ_EN undefined: same frame → no strobes; miso returns 0xA0 for all 5 bytes; ctrl=3.
- Reset mid-frame: assert rst_n low during an address byte with ssel held low → all outputs take reset values; bytes clocked before ssel toggles high produce no strobes.
